// File: rtl/o_linebuf_reader.sv
// Raster timing generator that reads a ping-pong pair of line buffers as packed
// words, unpacks them to pixels and tracks PS line fills against display demand.
module o_linebuf_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int DATA_W   = 32,
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = 32
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              line_ack,
    output logic              vsync,
    output logic              hsync,
    output logic              vde,
    output logic [ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]  o_data,
    output logic              req_line,
    output logic [11:0]       req_line_num,
    output logic              req_frame,
    output logic              underrun
);
    localparam int PPW    = DATA_W / PIX_W;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [11:0] HA      = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] VA      = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] PPW12   = 12'(PPW);

    logic [11:0] hcnt, vcnt;
    logic        act, hs, vs, frame_evt, line_start, line_end, pix_blank;
    logic [LANE_W-1:0] lane, lane_d1;
    logic [11:0] word_idx;
    logic        line_blank, blank_d1;
    logic [1:0]  valid, valid_nxt;
    logic        fill_ptr, fill_ptr_nxt;
    logic [2:1]  vld_pipe, hs_pipe, vs_pipe;
    logic [PPW-1:0][PIX_W-1:0] words;

    assign words = i_data;

    assign act        = (hcnt < HA) && (vcnt < VA);
    assign hs         = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs         = (vcnt >= VS_BEG) && (vcnt < VS_END);
    assign frame_evt  = (hcnt == '0) && (vcnt == VA);
    assign line_start = (hcnt == '0) && (vcnt < VA);
    assign line_end   = (hcnt == HA) && (vcnt < VA);
    assign lane       = LANE_W'(hcnt % PPW12);
    assign word_idx   = hcnt / PPW12;

    // First pixel of a line sees the fill state directly; later pixels use the latched decision.
    assign pix_blank  = (hcnt == '0) ? ~valid[vcnt[0]] : line_blank;

    // Frame clear first, then line-end clear, then the ack: an ack always lands on the cleared view.
    always_comb begin
        valid_nxt    = valid;
        fill_ptr_nxt = fill_ptr;
        if (frame_evt) begin
            valid_nxt    = '0;
            fill_ptr_nxt = 1'b0;
        end
        if (line_end)
            valid_nxt[vcnt[0]] = 1'b0;
        if (line_ack && !valid_nxt[fill_ptr_nxt]) begin
            valid_nxt[fill_ptr_nxt] = 1'b1;
            fill_ptr_nxt            = ~fill_ptr_nxt;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            hcnt         <= '0;
            vcnt         <= VA;
            valid        <= '0;
            fill_ptr     <= 1'b0;
            line_blank   <= 1'b0;
            underrun     <= 1'b0;
            req_frame    <= 1'b0;
            req_line     <= 1'b0;
            req_line_num <= '0;
            addr         <= '0;
            vld_pipe     <= '0;
            hs_pipe      <= '0;
            vs_pipe      <= '0;
            blank_d1     <= 1'b0;
            lane_d1      <= '0;
            o_data       <= '0;
        end else begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
            end else begin
                hcnt <= hcnt + 12'd1;
            end

            req_frame <= frame_evt;
            req_line  <= line_end && (vcnt + 12'd2 < VA);
            if (line_end && (vcnt + 12'd2 < VA))
                req_line_num <= vcnt + 12'd2;

            valid    <= valid_nxt;
            fill_ptr <= fill_ptr_nxt;

            if (line_start) begin
                line_blank <= ~valid[vcnt[0]];
                if (!valid[vcnt[0]])
                    underrun <= 1'b1;
            end

            if (act && (lane == '0))
                addr <= {vcnt[0], (ADDR_W-1)'(word_idx)};

            vld_pipe <= {vld_pipe[1], act};
            hs_pipe  <= {hs_pipe[1], hs};
            vs_pipe  <= {vs_pipe[1], vs};
            blank_d1 <= pix_blank;
            lane_d1  <= lane;
            o_data   <= (vld_pipe[1] && !blank_d1) ? words[lane_d1] : '0;
        end
    end

    assign vde   = vld_pipe[2];
    assign hsync = hs_pipe[2] ? SYNC_POL : ~SYNC_POL;
    assign vsync = vs_pipe[2] ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_o_linebuf_reader.sv
// Scoreboarded bench for o_linebuf_reader: a reference raster/fill model pushes
// expected pipeline and register outputs; they are popped when the DUT presents them.
module tb_o_linebuf_reader;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        line_ack = 1'b0;
    logic [31:0] i_data, addr;
    logic        vsync, hsync, vde, req_line, req_frame, underrun;
    logic [7:0]  o_data;
    logic [11:0] req_line_num;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    o_linebuf_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .DATA_W(32), .PIX_W(8), .ADDR_W(32)
    ) dut (
        .pclk(pclk), .reset(reset), .i_data(i_data), .line_ack(line_ack),
        .vsync(vsync), .hsync(hsync), .vde(vde), .addr(addr), .o_data(o_data),
        .req_line(req_line), .req_line_num(req_line_num), .req_frame(req_frame),
        .underrun(underrun)
    );

    // Line buffer contents: half h, word w holds pixels h*0x80 + 4w .. +3, lane 0 in the LSBs.
    function automatic logic [31:0] lbuf_word(input logic [31:0] a);
        logic [7:0] b;
        b = (a[31] ? 8'h80 : 8'h00) + {a[5:0], 2'b00};
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always_comb i_data = lbuf_word(addr);

    typedef struct packed {
        logic       vde;
        logic       hs;
        logic       vs;
        logic [7:0] pix;
    } pix_t;

    typedef struct packed {
        logic        frame;
        logic        line;
        logic [11:0] num;
        logic        und;
        logic [31:0] addr;
    } reg_t;

    pix_t pq[$];
    reg_t rq[$];

    int          hc, vc, fr, pend;
    logic [1:0]  mv;
    logic        mp, mu, mb;
    logic [31:0] ma;
    logic [11:0] mn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_init();
        hc = 0; vc = VA; mv = '0; mp = 1'b0; mu = 1'b0; mb = 1'b0;
        ma = '0; mn = '0; pend = 0;
        pq.delete();
        rq.delete();
    endtask

    task automatic do_reset();
        @(negedge pclk);
        reset = 1'b1;
        line_ack = 1'b0;
        @(negedge pclk);
        chk("rst_vde", 32'(vde), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_addr", addr, 32'd0);
        chk("rst_req_frame", 32'(req_frame), 32'd0);
        chk("rst_req_line", 32'(req_line), 32'd0);
        chk("rst_req_num", 32'(req_line_num), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        model_init();
    endtask

    task automatic step();
        pix_t p;
        reg_t r;
        logic ack, act, blk;
        @(negedge pclk);
        reset = 1'b0;
        if (pq.size() == 2) begin
            p = pq.pop_front();
            chk("vde", 32'(vde), 32'(p.vde));
            chk("hsync", 32'(hsync), 32'(p.hs));
            chk("vsync", 32'(vsync), 32'(p.vs));
            chk("o_data", 32'(o_data), 32'(p.pix));
        end
        if (rq.size() == 1) begin
            r = rq.pop_front();
            chk("req_frame", 32'(req_frame), 32'(r.frame));
            chk("req_line", 32'(req_line), 32'(r.line));
            chk("req_line_num", 32'(req_line_num), 32'(r.num));
            chk("underrun", 32'(underrun), 32'(r.und));
            chk("addr", addr, r.addr);
        end

        if (hc == 0 && vc == VA) fr++;

        // PS: two fills per frame request, one per line request; frames 2/3 alter the pattern.
        if (req_frame) pend += (fr == 2) ? 1 : 2;
        if (req_line && !((fr == 2 || fr == 3) && req_line_num == 12'd2)) pend++;
        ack = 1'b0;
        if (pend > 0) begin ack = 1'b1; pend--; end
        if (fr == 1 && hc == 5 && vc == VA + 1) ack = 1'b1;   // both halves full: ignored
        if (fr == 2 && hc == 0 && vc == VA) ack = 1'b1;       // same cycle as frame clear
        if (fr == 2 && hc == HA && vc == 0) ack = 1'b1;       // same cycle as line-0 end clear
        line_ack = ack;

        act = (hc < HA) && (vc < VA);
        blk = (hc == 0) ? !mv[vc % 2] : mb;
        p.vde = act;
        p.hs  = !(hc >= HA + HF && hc < HA + HF + HS);
        p.vs  = !(vc >= VA + VF && vc < VA + VF + VS);
        p.pix = (act && !blk) ? 8'((vc % 2) * 128 + hc) : 8'h00;

        r.frame = (hc == 0 && vc == VA);
        r.line  = 1'b0;
        if (act && hc % 4 == 0) ma = {1'(vc % 2), 31'(hc / 4)};
        if (hc == 0 && vc < VA) begin
            mb = !mv[vc % 2];
            if (mb) mu = 1'b1;
        end
        if (hc == HA && vc < VA) begin
            mv[vc % 2] = 1'b0;
            if (vc + 2 < VA) begin
                r.line = 1'b1;
                mn = 12'(vc + 2);
            end
        end
        if (r.frame) begin mv = '0; mp = 1'b0; end
        if (ack && !mv[mp]) begin mv[mp] = 1'b1; mp = !mp; end
        r.num  = mn;
        r.und  = mu;
        r.addr = ma;
        pq.push_back(p);
        rq.push_back(r);

        hc++;
        if (hc == HT) begin
            hc = 0;
            vc++;
            if (vc == VT) vc = 0;
        end
    endtask

    initial begin
        int n;
        fr = 0;
        do_reset();
        n = 0;
        // Frames 1..4 exercise normal fill, coincident acks and a withheld line; reset lands mid line 1.
        while (fr < 5 || !(vc == 1 && hc == 3)) begin
            step();
            n++;
            if (n > 5000) begin
                chk("loop_bound", 32'(n), 32'd5000);
                break;
            end
        end
        do_reset();
        repeat (2 * HT * VT) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
